// File: rtl/complex_delay_line.sv
// Valid-gated complex sample delay: each accepted re/im pair reappears exactly D accepts later.
// Optional build macro COMPLEX_DELAY_ZERO_UNPRIMED_EN zeroes out_re/out_im whenever out_valid is low.
module complex_delay_line #(
    parameter  int WIDTH     = 16,
    parameter  int MAX_DEPTH = 64,
    localparam int AW        = $clog2(MAX_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic [AW:0]             depth,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_re,
    input  logic signed [WIDTH-1:0] in_im,
    output logic                    out_valid,
    output logic signed [WIDTH-1:0] out_re,
    output logic signed [WIDTH-1:0] out_im,
    output logic                    primed
);

    localparam int unsigned AW1  = AW + 1;
    localparam logic [AW:0] MAXD = AW1'(MAX_DEPTH);

    logic signed [WIDTH-1:0] mem_re [MAX_DEPTH];
    logic signed [WIDTH-1:0] mem_im [MAX_DEPTH];

    logic [AW-1:0] wptr;
    logic [AW-1:0] rd_addr;
    logic [AW:0]   fill;
    logic [AW:0]   fill_nxt;
    logic [AW:0]   depth_q;
    logic [AW:0]   depth_clamp;
    logic          accept;
    logic          depth_chg;
    logic          ov_nxt;

    always_comb begin
        if (depth == '0)
            depth_clamp = AW1'(1);
        else if (depth > MAXD)
            depth_clamp = MAXD;
        else
            depth_clamp = depth;
    end

    assign accept    = in_valid & ~flush;
    assign depth_chg = (depth_clamp != depth_q);
    // depth_q == MAX_DEPTH has zero low bits, so the read lands on wptr (oldest slot)
    assign rd_addr   = wptr - depth_q[AW-1:0];

    // A depth change restarts the fill count so stale contents are never emitted
    always_comb begin
        fill_nxt = fill;
        ov_nxt   = 1'b0;
        if (flush) begin
            fill_nxt = '0;
        end else if (depth_chg) begin
            fill_nxt = accept ? AW1'(1) : '0;
        end else if (accept) begin
            ov_nxt = (fill >= depth_q);
            if (fill != MAXD)
                fill_nxt = fill + AW1'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_re[wptr] <= in_re;
            mem_im[wptr] <= in_im;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            fill      <= '0;
            depth_q   <= '0;
            out_valid <= 1'b0;
            primed    <= 1'b0;
            out_re    <= '0;
            out_im    <= '0;
        end else begin
            depth_q   <= depth_clamp;
            fill      <= fill_nxt;
            out_valid <= ov_nxt;
            primed    <= (fill_nxt >= depth_clamp);
            if (flush)
                wptr <= '0;
            else if (accept)
                wptr <= wptr + AW'(1);
            if (ov_nxt) begin
                out_re <= mem_re[rd_addr];
                out_im <= mem_im[rd_addr];
            end
`ifdef COMPLEX_DELAY_ZERO_UNPRIMED_EN
            else begin
                out_re <= '0;
                out_im <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_complex_delay_line.sv
// Directed bench for complex_delay_line: fill latency, stalls, wrap, clamping, depth change, flush, reset.
module tb_complex_delay_line;

    localparam int WIDTH     = 16;
    localparam int MAX_DEPTH = 64;
    localparam int AW        = 6;
`ifdef COMPLEX_DELAY_ZERO_UNPRIMED_EN
    localparam bit ZERO_MODE = 1'b1;
`else
    localparam bit ZERO_MODE = 1'b0;
`endif

    logic                    clk;
    logic                    rst_n;
    logic                    flush;
    logic [AW:0]             depth;
    logic                    in_valid;
    logic signed [WIDTH-1:0] in_re;
    logic signed [WIDTH-1:0] in_im;
    logic                    out_valid;
    logic signed [WIDTH-1:0] out_re;
    logic signed [WIDTH-1:0] out_im;
    logic                    primed;

    complex_delay_line #(
        .WIDTH    (WIDTH),
        .MAX_DEPTH(MAX_DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .depth    (depth),
        .in_valid (in_valid),
        .in_re    (in_re),
        .in_im    (in_im),
        .out_valid(out_valid),
        .out_re   (out_re),
        .out_im   (out_im),
        .primed   (primed)
    );

    always #5 clk = ~clk;

    int n_cmp   = 0;
    int n_err   = 0;
    int hold_re = 0;
    int hold_im = 0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected data when not valid: zero in zero mode, otherwise the last valid value
    task automatic expect_out(input string tag, input bit ev, input int er, input int ei);
        int xr;
        int xi;
        if (ev) begin
            xr = er; xi = ei; hold_re = er; hold_im = ei;
        end else if (ZERO_MODE) begin
            xr = 0; xi = 0;
        end else begin
            xr = hold_re; xi = hold_im;
        end
        check({tag, ".valid"}, out_valid, ev);
        check({tag, ".re"}, out_re, xr);
        check({tag, ".im"}, out_im, xi);
    endtask

    task automatic cyc(input bit v, input int re, input int im);
        in_valid = v;
        in_re    = WIDTH'(re);
        in_im    = WIDTH'(im);
        @(posedge clk);
        #1;
    endtask

    bit pat [8];
    int n;

    initial begin
        clk = 0; rst_n = 0; flush = 0; depth = 7'd4;
        in_valid = 0; in_re = '0; in_im = '0;
        #12;
        expect_out("reset", 0, 0, 0);
        check("reset.primed", primed, 0);
        @(negedge clk);
        rst_n = 1;

        // continuous feed at D=4
        for (int i = 1; i <= 10; i++) begin
            cyc(1, i, -i);
            expect_out("t1", i > 4, i - 4, -(i - 4));
            check("t1.primed", primed, i >= 4);
        end

        // stalls at D=4
        flush = 1;
        cyc(0, 0, 0);
        flush = 0;
        expect_out("t2.flush", 0, 0, 0);
        check("t2.primed", primed, 0);
        pat = '{1, 0, 0, 1, 1, 0, 1, 1};
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (pat[k]) n++;
            cyc(pat[k], n, -n);
            expect_out("t2", pat[k] && n == 5, 1, -1);
        end

        // D = MAX_DEPTH with pointer wrap
        depth = 7'd64;
        for (int i = 1; i <= 130; i++) begin
            cyc(1, i, -i);
            expect_out("t3", i > 64, i - 64, -(i - 64));
        end
        check("t3.primed", primed, 1);

        // depth 0 clamps to 1, then oversize clamps to 64
        depth = 7'd0;
        for (int i = 1; i <= 5; i++) begin
            cyc(1, 100 + i, -(100 + i));
            expect_out("t4a", i > 1, 100 + i - 1, -(100 + i - 1));
        end
        depth = 7'd127;
        for (int i = 1; i <= 66; i++) begin
            cyc(1, 200 + i, -(200 + i));
            expect_out("t4b", i > 64, 200 + i - 64, -(200 + i - 64));
        end

        // mid-stream change 8 -> 2
        depth = 7'd8;
        for (int i = 1; i <= 20; i++) begin
            cyc(1, 300 + i, -(300 + i));
            expect_out("t5a", i > 8, 300 + i - 8, -(300 + i - 8));
        end
        depth = 7'd2;
        for (int m = 1; m <= 6; m++) begin
            cyc(1, 400 + m, -(400 + m));
            expect_out("t5b", m >= 3, 400 + m - 2, -(400 + m - 2));
        end

        // flush with in_valid at D=3
        depth = 7'd3;
        for (int i = 1; i <= 10; i++) begin
            cyc(1, 500 + i, -(500 + i));
            expect_out("t6a", i > 3, 500 + i - 3, -(500 + i - 3));
        end
        flush = 1;
        cyc(1, 999, -999);
        flush = 0;
        expect_out("t6.flush", 0, 0, 0);
        check("t6.flush.primed", primed, 0);
        for (int j = 1; j <= 5; j++) begin
            cyc(1, 600 + j, -(600 + j));
            expect_out("t6b", j > 3, 600 + j - 3, -(600 + j - 3));
            check("t6b.primed", primed, j >= 3);
        end

        // asynchronous reset mid-stream
        #2;
        rst_n = 0;
        #1;
        check("t7.rst.valid", out_valid, 0);
        check("t7.rst.re", out_re, 0);
        check("t7.rst.im", out_im, 0);
        check("t7.rst.primed", primed, 0);
        hold_re = 0;
        hold_im = 0;
        @(negedge clk);
        rst_n = 1;
        for (int i = 1; i <= 5; i++) begin
            cyc(1, 700 + i, -(700 + i));
            expect_out("t7", i > 3, 700 + i - 3, -(700 + i - 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
